if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Instruction-fetch requester on the slow instruction-ROM interface (pc out; instr + 1-cycle ready pulse in).
//  - Holds mem_pc stable until the ROM answers.
//  - Buffers each answered {pc, instr} in a small FIFO.
//  - Presents the FIFO head to decode with a valid/ready handshake.
//  - Handles branch redirects: flushes the FIFO and discards stale ROM answers.
//  Sits between the ROM and the IF/ID pipeline register of the five-stage core.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address loaded by rst
//  BUF_DEPTH  2              FIFO entries; power of 2, >=2
//  NOP_INSTR  32'h0000_0013  addi x0,x0,0; driven on if_instr while FIFO empty
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous reset, active-high
//  mem_pc          out  32  byte address presented to ROM; low 2 bits always 0
//  mem_instr       in   32  ROM data; meaningful only while mem_ready=1
//  mem_ready       in   1   ROM answer pulse for the pc held on the previous edge
//  redirect_valid  in   1   branch/jump taken; restart fetch at redirect_pc
//  redirect_pc     in   32  redirect target; bits[1:0] ignored (forced 0)
//  if_valid        out  1   FIFO head valid toward decode
//  if_instr        out  32  head instruction; NOP_INSTR when if_valid=0
//  if_pc           out  32  head pc; 32'h0 when if_valid=0
//  id_ready        in   1   decode accepts head this cycle
//  perf_fetch_cnt  out  32  accepted ROM answers (FETCH_PERF_EN)
//  perf_stall_cnt  out  32  decode-starved cycles (FETCH_PERF_EN)
// BEHAVIOUR
//  Reset:
//   - mem_pc=RESET_PC; FIFO empty; if_valid=0; if_instr=NOP_INSTR; if_pc=0; perf counters=0.
//   - pc_stable=0, so a mem_ready high during or right after reset is dropped.
//  pc_stable:
//   - Reg, 0 on any edge where mem_pc changes; 1 on edges where mem_pc holds.
//   - The ROM samples pc on the edge that raises ready, so an answer after a pc change carries the old pc.
//  pop   = if_valid & id_ready.
//  accept = mem_ready & pc_stable & ~redirect_valid & (~full | pop).
//   - On accept: push {mem_pc, mem_instr} at tail; mem_pc <= mem_pc+4 (wraps at 2^32).
//   - mem_ready while full and no pop: answer dropped; mem_pc held; ROM re-answers the same pc later.
//  Push and pop in the same cycle are legal at any occupancy, including full; count is unchanged.
//  FIFO outputs are registered: no empty bypass. A pushed entry is visible on if_valid the cycle after the push edge.
//  Redirect (highest priority):
//   - FIFO flushed; mem_pc <= {redirect_pc[31:2],2'b00}; pc_stable <= 0.
//   - Same-cycle accept and pop are suppressed.
//   - Next cycle: if_valid=0.
//   - Redirect to the current mem_pc still clears pc_stable for one cycle.
//  Back-to-back redirects: last one wins; no answer is accepted until mem_pc is stable for one edge.
//  rst mid-operation: overrides everything, including redirect; state returns to reset values in one cycle.
//  if_instr/if_pc are stable while if_valid=1 and id_ready=0.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//   - perf_fetch_cnt +1 per accept.
//   - perf_stall_cnt +1 per cycle with id_ready=1 & if_valid=0 & ~redirect_valid.
//   - Both wrap at 2^32; cleared only by rst.
//  FETCH_PERF_EN undefined: both ports tied 32'h0; no counter flops.
// TESTING (ROM model: ready pulse every 7th cycle, instr=mem[pc>>2], mem[i]=32'hA000_0000+i)
//  T1: rst 2 cycles, id_ready=1 -> mem_pc=0; first answer gives if_pc=0/if_instr=A0000000; then if_pc 4,8,C; each valid exactly 1 cycle.
//  T2: ready=1 in first cycle after rst -> dropped; perf_fetch_cnt stays 0 until first real answer.
//  T3: id_ready=0, BUF_DEPTH=2 -> after 2 answers mem_pc=8 held; 3rd answer dropped; id_ready=1 -> if_pc 0,4,8 in order, none lost or duplicated.
//  T4: redirect_pc=32'h43 asserted 1 cycle before an answer for pc 8 -> answer dropped; FIFO empty; mem_pc=40; next accepted if_pc=40, instr=A0000010.
//  T5: redirect in same cycle as pop and full FIFO -> FIFO empty next cycle; no push; perf_fetch_cnt unchanged.
//  T6: FETCH_PERF_EN, run T1 for 50 cycles -> perf_fetch_cnt=answers accepted; perf_stall_cnt=cycles with if_valid=0; both 0 when macro undefined.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch requester: holds the ROM address, buffers answers in a small FIFO,
// and serves decode with valid/ready. Optional perf counters under FETCH_PERF_EN.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_instr,
  input  logic        mem_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      buf_pc    [BUF_DEPTH];
  logic [31:0]      buf_instr [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pc_stable;
  logic             full;
  logic             pop_req;
  logic             pop;
  logic             accept;
  logic [31:0]      pc_next;
  logic [1:0]       unused_bits;

  assign unused_bits = redirect_pc[1:0];

  assign full     = (count == CNT_W'(BUF_DEPTH));
  assign if_valid = (count != '0);
  assign pop_req  = if_valid & id_ready;
  assign pop      = pop_req & ~redirect_valid;
  assign accept   = mem_ready & pc_stable & ~redirect_valid & (~full | pop_req);

  assign if_instr = if_valid ? buf_instr[rd_ptr] : NOP_INSTR;
  assign if_pc    = if_valid ? buf_pc[rd_ptr]    : 32'h0;

  always_comb begin
    pc_next = mem_pc;
    if (redirect_valid)
      pc_next = {redirect_pc[31:2], 2'b00};
    else if (accept)
      pc_next = mem_pc + 32'd4;
  end

  // Control state: address, stability flag and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_pc    <= {RESET_PC[31:2], 2'b00};
      pc_stable <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      mem_pc    <= pc_next;
      // A redirect to the same address still restarts the ROM, so stability drops.
      pc_stable <= ~redirect_valid & (pc_next == mem_pc);
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
        case ({accept, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage carries data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_pc[wr_ptr]    <= mem_pc;
      buf_instr[wr_ptr] <= mem_instr;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (accept)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (id_ready & ~if_valid & ~redirect_valid)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule
